// File: rtl/wb_classic_arbiter_if.sv
// Bus bundle for wb_classic_arbiter: NUM_CTRL Wishbone classic controller ports
// plus the single shared device port and the arbiter's observability outputs.
interface wb_classic_arbiter_if #(
  parameter int NUM_CTRL  = 4,
  parameter int DAT_WIDTH = 8
);
  localparam int GW = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;

  logic [NUM_CTRL-1:0]           c_cyc_i;
  logic [NUM_CTRL-1:0]           c_stb_i;
  logic [NUM_CTRL-1:0]           c_we_i;
  logic [NUM_CTRL*DAT_WIDTH-1:0] c_dat_i;
  logic [NUM_CTRL-1:0]           c_ack_o;
  logic [NUM_CTRL-1:0]           c_err_o;
  logic [NUM_CTRL-1:0]           c_rty_o;
  logic [DAT_WIDTH-1:0]          c_dat_o;
  logic                          d_cyc_o;
  logic                          d_stb_o;
  logic                          d_we_o;
  logic [DAT_WIDTH-1:0]          d_dat_o;
  logic                          d_ack_i;
  logic                          d_err_i;
  logic                          d_rty_i;
  logic [DAT_WIDTH-1:0]          d_dat_i;
  logic [GW-1:0]                 grant_o;
  logic                          busy_o;

  // Arbiter view of the bundle
  modport slave (
    input  c_cyc_i, c_stb_i, c_we_i, c_dat_i, d_ack_i, d_err_i, d_rty_i, d_dat_i,
    output c_ack_o, c_err_o, c_rty_o, c_dat_o, d_cyc_o, d_stb_o, d_we_o, d_dat_o,
           grant_o, busy_o
  );

  // Environment view: controllers and device driving the arbiter
  modport master (
    output c_cyc_i, c_stb_i, c_we_i, c_dat_i, d_ack_i, d_err_i, d_rty_i, d_dat_i,
    input  c_ack_o, c_err_o, c_rty_o, c_dat_o, d_cyc_o, d_stb_o, d_we_o, d_dat_o,
           grant_o, busy_o
  );
endinterface

// File: rtl/wb_classic_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 classic device among NUM_CTRL controllers.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_classic_arbiter #(
  parameter int NUM_CTRL       = 4,
  parameter int DAT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  wb_classic_arbiter_if.slave   bus
);
  localparam int GW = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;

  if (NUM_CTRL < 2 || NUM_CTRL > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("wb_classic_arbiter: unsupported parameter values");
  end

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         ptr_q, ptr_d;
  logic [GW-1:0]         winner;
  logic                  found;
  logic                  owner_cyc;
  logic                  owner_stb;
  logic                  resp;
  logic                  tmo_hit;
  logic                  d_cyc, d_stb, d_we;
  logic [DAT_WIDTH-1:0]  d_dat;
  logic [NUM_CTRL-1:0]   c_ack, c_err, c_rty;

  assign owner_cyc = bus.c_cyc_i[grant_q];
  assign owner_stb = bus.c_stb_i[grant_q];
  assign resp      = bus.d_ack_i | bus.d_err_i | bus.d_rty_i;

  // First requester at or above the pointer, wrapping around
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (!found && bus.c_cyc_i[(int'(ptr_q) + i) % NUM_CTRL]) begin
        winner = GW'((int'(ptr_q) + i) % NUM_CTRL);
        found  = 1'b1;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q == GRANTED) && (tmo_q == TW'(TIMEOUT_CYCLES));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q != GRANTED || tmo_hit || resp) begin
      tmo_d = '0;
    end else if (owner_stb) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // The owner keeps the grant until it drops cyc; the pointer then moves past it
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    d_cyc   = 1'b0;
    d_stb   = 1'b0;
    d_we    = 1'b0;
    d_dat   = '0;
    c_ack   = '0;
    c_err   = '0;
    c_rty   = '0;
    case (state_q)
      IDLE: begin
        if (|bus.c_cyc_i) begin
          grant_d = winner;
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        d_cyc = owner_cyc;
        d_stb = owner_stb;
        d_we  = bus.c_we_i[grant_q];
        d_dat = bus.c_dat_i[int'(grant_q)*DAT_WIDTH +: DAT_WIDTH];
        c_ack[grant_q] = bus.d_ack_i;
        c_err[grant_q] = bus.d_err_i;
        c_rty[grant_q] = bus.d_rty_i;
        if (tmo_hit) begin
          d_stb          = 1'b0;
          c_ack[grant_q] = 1'b0;
          c_err[grant_q] = 1'b1;
          c_rty[grant_q] = 1'b0;
        end
        if (!owner_cyc) begin
          state_d = IDLE;
          ptr_d   = GW'((int'(grant_q) + 1) % NUM_CTRL);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.d_cyc_o = d_cyc;
  assign bus.d_stb_o = d_stb;
  assign bus.d_we_o  = d_we;
  assign bus.d_dat_o = d_dat;
  assign bus.c_ack_o = c_ack;
  assign bus.c_err_o = c_err;
  assign bus.c_rty_o = c_rty;
  assign bus.c_dat_o = bus.d_dat_i;
  assign bus.grant_o = grant_q;
  assign bus.busy_o  = (state_q == GRANTED);
endmodule

// File: tb/tb_wb_classic_arbiter.sv
// Directed bench for wb_classic_arbiter: vector table plus hand-written
// round-robin, reset-abort and watchdog sequences.
module tb_wb_classic_arbiter;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   errors = 0;
  int   checks = 0;

  wb_classic_arbiter_if #(.NUM_CTRL(4), .DAT_WIDTH(8)) bus ();

  wb_classic_arbiter #(.NUM_CTRL(4), .DAT_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] cyc, stb, we;
    logic       ack, err, rty;
    logic [7:0] ddat;
    logic       e_cyc, e_stb, e_we;
    logic [7:0] e_dat;
    logic [1:0] e_gnt;
    logic       e_busy;
    logic [3:0] e_ack, e_err, e_rty;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  function automatic vec_t mkVec(
    input logic [3:0] cyc, input logic [3:0] stb, input logic [3:0] we,
    input logic ack, input logic err, input logic rty, input logic [7:0] ddat,
    input logic e_cyc, input logic e_stb, input logic e_we, input logic [7:0] e_dat,
    input logic [1:0] e_gnt, input logic e_busy,
    input logic [3:0] e_ack, input logic [3:0] e_err, input logic [3:0] e_rty);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.we = we; v.ack = ack; v.err = err; v.rty = rty;
    v.ddat = ddat; v.e_cyc = e_cyc; v.e_stb = e_stb; v.e_we = e_we; v.e_dat = e_dat;
    v.e_gnt = e_gnt; v.e_busy = e_busy; v.e_ack = e_ack; v.e_err = e_err; v.e_rty = e_rty;
    return v;
  endfunction

  task automatic checkField(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.c_cyc_i = v.cyc;
    bus.c_stb_i = v.stb;
    bus.c_we_i  = v.we;
    bus.d_ack_i = v.ack;
    bus.d_err_i = v.err;
    bus.d_rty_i = v.rty;
    bus.d_dat_i = v.ddat;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    checkField($sformatf("v%0d d_cyc", idx), {7'd0, bus.d_cyc_o}, {7'd0, v.e_cyc});
    checkField($sformatf("v%0d d_stb", idx), {7'd0, bus.d_stb_o}, {7'd0, v.e_stb});
    checkField($sformatf("v%0d d_we", idx),  {7'd0, bus.d_we_o},  {7'd0, v.e_we});
    checkField($sformatf("v%0d d_dat", idx), bus.d_dat_o, v.e_dat);
    checkField($sformatf("v%0d grant", idx), {6'd0, bus.grant_o}, {6'd0, v.e_gnt});
    checkField($sformatf("v%0d busy", idx),  {7'd0, bus.busy_o},  {7'd0, v.e_busy});
    checkField($sformatf("v%0d c_ack", idx), {4'd0, bus.c_ack_o}, {4'd0, v.e_ack});
    checkField($sformatf("v%0d c_err", idx), {4'd0, bus.c_err_o}, {4'd0, v.e_err});
    checkField($sformatf("v%0d c_rty", idx), {4'd0, bus.c_rty_o}, {4'd0, v.e_rty});
    checkField($sformatf("v%0d c_dat", idx), bus.c_dat_o, v.ddat);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Single owner 2, then pointer 3 picks 3 over 0, error passthrough, back-to-back owner 1
    vecs[0]  = mkVec(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    vecs[1]  = mkVec(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h12, 2'd2, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    vecs[2]  = vecs[1];
    vecs[3]  = mkVec(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h12, 2'd2, 1'b1, 4'b0100, 4'b0000, 4'b0000);
    vecs[4]  = mkVec(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h12, 2'd2, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    vecs[5]  = mkVec(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    vecs[6]  = mkVec(4'b1001, 4'b1001, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    vecs[7]  = mkVec(4'b1001, 4'b1001, 4'b0000, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h13, 2'd3, 1'b1, 4'b0000, 4'b1000, 4'b0000);
    vecs[8]  = mkVec(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h13, 2'd3, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    vecs[9]  = mkVec(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd3, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    vecs[10] = mkVec(4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h10, 2'd0, 1'b1, 4'b0001, 4'b0000, 4'b0000);
    vecs[11] = mkVec(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h10, 2'd0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    vecs[12] = mkVec(4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    vecs[13] = mkVec(4'b0011, 4'b0011, 4'b0010, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 2'd1, 1'b1, 4'b0010, 4'b0000, 4'b0000);
    vecs[14] = mkVec(4'b0011, 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 2'd1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    vecs[15] = vecs[13];
    vecs[16] = vecs[13];
    vecs[17] = mkVec(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h11, 2'd1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    vecs[18] = mkVec(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    vecs[19] = mkVec(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h10, 2'd0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    vecs[20] = mkVec(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 2'd0, 1'b1, 4'b0000, 4'b0000, 4'b0001);
    vecs[21] = vecs[11];
    vecs[22] = mkVec(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);

    bus.c_dat_i = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.c_cyc_i = 4'b1111;
    bus.c_stb_i = 4'b1111;
    bus.c_we_i  = 4'b1111;
    bus.d_ack_i = 1'b1;
    bus.d_err_i = 1'b1;
    bus.d_rty_i = 1'b1;
    bus.d_dat_i = 8'h5A;

    // Outputs must stay quiet while reset is held even with every input active
    repeat (2) @(negedge clk_i);
    #1;
    checkField("reset d_cyc", {7'd0, bus.d_cyc_o}, 8'd0);
    checkField("reset d_stb", {7'd0, bus.d_stb_o}, 8'd0);
    checkField("reset d_dat", bus.d_dat_o, 8'd0);
    checkField("reset grant", {6'd0, bus.grant_o}, 8'd0);
    checkField("reset busy", {7'd0, bus.busy_o}, 8'd0);
    checkField("reset c_ack", {4'd0, bus.c_ack_o}, 8'd0);
    checkField("reset c_err", {4'd0, bus.c_err_o}, 8'd0);
    checkField("reset c_dat", bus.c_dat_o, 8'h5A);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i, vecs[i]);
      @(negedge clk_i);
    end

    // Round robin from a fresh reset: order 0,1,2,3,0 with one IDLE clock between owners
    rst_ni = 1'b0;
    #1;
    rst_ni = 1'b1;
    bus.c_cyc_i = 4'b1111;
    bus.c_stb_i = 4'b1111;
    bus.c_we_i  = 4'b0000;
    bus.d_dat_i = 8'h00;
    for (int r = 0; r < 5; r++) begin
      #1;
      checkField($sformatf("rr%0d idle busy", r), {7'd0, bus.busy_o}, 8'd0);
      @(negedge clk_i);
      bus.d_ack_i = 1'b1;
      #1;
      checkField($sformatf("rr%0d grant", r), {6'd0, bus.grant_o}, 8'(r % 4));
      checkField($sformatf("rr%0d c_ack", r), {4'd0, bus.c_ack_o}, 8'(1 << (r % 4)));
      @(negedge clk_i);
      bus.d_ack_i = 1'b0;
      bus.c_cyc_i = 4'b1111 & ~(4'b0001 << (r % 4));
      #1;
      checkField($sformatf("rr%0d release d_cyc", r), {7'd0, bus.d_cyc_o}, 8'd0);
      @(negedge clk_i);
      bus.c_cyc_i = 4'b1111;
    end

    // Reset pulse in the middle of owner 2's transfer, then controller 3 alone
    bus.c_cyc_i = 4'b0100;
    bus.c_stb_i = 4'b0100;
    @(negedge clk_i);
    #1;
    checkField("abort pre grant", {6'd0, bus.grant_o}, 8'd2);
    checkField("abort pre d_cyc", {7'd0, bus.d_cyc_o}, 8'd1);
    rst_ni = 1'b0;
    #1;
    checkField("abort d_cyc", {7'd0, bus.d_cyc_o}, 8'd0);
    checkField("abort grant", {6'd0, bus.grant_o}, 8'd0);
    checkField("abort busy", {7'd0, bus.busy_o}, 8'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    bus.c_cyc_i = 4'b1000;
    bus.c_stb_i = 4'b1000;
    #1;
    checkField("post reset idle busy", {7'd0, bus.busy_o}, 8'd0);
    @(negedge clk_i);
    #1;
    checkField("post reset grant", {6'd0, bus.grant_o}, 8'd3);
    checkField("post reset d_cyc", {7'd0, bus.d_cyc_o}, 8'd1);

    // Owner 0 stalled by a silent device
    @(negedge clk_i);
    bus.c_cyc_i = 4'b0000;
    bus.c_stb_i = 4'b0000;
    @(negedge clk_i);
    bus.c_cyc_i = 4'b0001;
    bus.c_stb_i = 4'b0001;
    @(negedge clk_i);
    for (int k = 1; k <= 20; k++) begin
      #1;
`ifdef WB_ARB_TIMEOUT_EN
      checkField($sformatf("stall%0d c_err", k), {4'd0, bus.c_err_o}, (k == 17) ? 8'd1 : 8'd0);
      checkField($sformatf("stall%0d d_stb", k), {7'd0, bus.d_stb_o}, (k == 17) ? 8'd0 : 8'd1);
`else
      checkField($sformatf("stall%0d c_err", k), {4'd0, bus.c_err_o}, 8'd0);
      checkField($sformatf("stall%0d d_stb", k), {7'd0, bus.d_stb_o}, 8'd1);
`endif
      @(negedge clk_i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
